// File: rtl/mul_share_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul_share_arbiter_if                                          |
// | Purpose  : Bundles the two requester channels and the multiplier channel |
// |            of mul_share_arbiter into one interface.                      |
// | Modports : slave  - the arbiter side (drives done/res/err, busy and the  |
// |                     multiplier start/operands)                           |
// |            master - the environment side (requesters plus the shared     |
// |                     multiplier unit)                                     |
// | Signals  : req0/a0/b0 -> done0/res0/err0  requester 0                    |
// |            req1/a1/b1 -> done1/res1/err1  requester 1                    |
// |            busy                            arbiter occupied              |
// |            mul_start/mul_a/mul_b -> mul_res/mul_end  multiplier link     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface mul_share_arbiter_if #(
  parameter int WIDTH = 32
) ();

  // Requester 0
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             done0;
  logic [WIDTH-1:0] res0;
  logic             err0;

  // Requester 1
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             done1;
  logic [WIDTH-1:0] res1;
  logic             err1;

  // Status
  logic             busy;

  // Shared multiplier
  logic             mul_start;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_res;
  logic             mul_end;

  modport slave (
    input  req0, a0, b0,
    input  req1, a1, b1,
    input  mul_res, mul_end,
    output done0, res0, err0,
    output done1, res1, err1,
    output busy,
    output mul_start, mul_a, mul_b
  );

  modport master (
    output req0, a0, b0,
    output req1, a1, b1,
    output mul_res, mul_end,
    input  done0, res0, err0,
    input  done1, res1, err1,
    input  busy,
    input  mul_start, mul_a, mul_b
  );

endinterface : mul_share_arbiter_if
`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul_share_arbiter                                             |
// | Purpose  : Shares one multi-cycle multiplier (level start, one-cycle end |
// |            pulse) between two requesters with round-robin arbitration,   |
// |            operand latching, start sequencing and result routing.        |
// | Params   : WIDTH   operand/result width                                  |
// |            TIMEOUT BUSY cycles before abort (timeout build only, >= 2)   |
// | Ports    : clk     clock, all logic on posedge                           |
// |            rst     synchronous active-high reset                         |
// |            bus_io  mul_share_arbiter_if.slave - requester 0/1 channels,  |
// |                    busy status and the multiplier start/operand/result   |
// |                    link                                                  |
// | Options  : `define MUL_ARB_TIMEOUT_EN to abort operations whose mul_end  |
// |            does not arrive within TIMEOUT BUSY cycles (err<n> reports    |
// |            the abort). Without it BUSY waits indefinitely, err0/err1 are |
// |            tied low and TIMEOUT is unused.                               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mul_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  wire                 clk,
  input  wire                 rst,
  mul_share_arbiter_if.slave  bus_io
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;          // requester owning the current op
  logic             rr_last_q, rr_last_d;  // requester served most recently
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic [WIDTH-1:0] res0_q, res0_d;
  logic [WIDTH-1:0] res1_q, res1_d;

  // Arbitration decision for the current IDLE cycle
  logic             any_req_w;
  logic             pick_w;

`ifdef MUL_ARB_TIMEOUT_EN
  // Counter runs 0..TIMEOUT-1 across the BUSY cycles of one operation.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;          // current op ended by timeout
`else
  // TIMEOUT only matters for the timeout build.
  logic             unused_timeout_w;
  assign unused_timeout_w = (TIMEOUT < 2);
`endif

  // --------------------------------------------------------------------------
  // Round-robin pick: a lone requester always wins; on a tie the requester
  // that was not served last goes next. rr_last resets to 1 so requester 0
  // wins the first tie.
  // --------------------------------------------------------------------------
  assign any_req_w = bus_io.req0 | bus_io.req1;
  assign pick_w    = (bus_io.req0 & bus_io.req1) ? ~rr_last_q : bus_io.req1;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      rr_last_q <= 1'b1;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      res0_q    <= '0;
      res1_q    <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_last_q <= rr_last_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      res0_q    <= res0_d;
      res1_q    <= res1_d;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_last_d = rr_last_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    res0_d    = res0_q;
    res1_d    = res1_q;
`ifdef MUL_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Operands are captured once here; later changes on a/b are ignored.
        if (any_req_w) begin
          gnt_d   = pick_w;
          mul_a_d = pick_w ? bus_io.a1 : bus_io.a0;
          mul_b_d = pick_w ? bus_io.b1 : bus_io.b0;
          state_d = S_BUSY;
`ifdef MUL_ARB_TIMEOUT_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end

      S_BUSY: begin
        // mul_end takes priority over an expiry in the same cycle.
        if (bus_io.mul_end) begin
          if (gnt_q) begin
            res1_d = bus_io.mul_res;
          end else begin
            res0_d = bus_io.mul_res;
          end
          state_d = S_DONE;
`ifdef MUL_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == C_CNT_LAST) begin
          // Abort: the owner gets a zero result flagged with err.
          if (gnt_q) begin
            res1_d = '0;
          end else begin
            res0_d = '0;
          end
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end

      S_DONE: begin
        rr_last_d = gnt_q;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: all derived from registered state, so every output is zero
  // straight after reset and done pulses are exactly one cycle long.
  // --------------------------------------------------------------------------
  assign bus_io.busy      = (state_q != S_IDLE);
  assign bus_io.mul_start = (state_q == S_BUSY);
  assign bus_io.mul_a     = mul_a_q;
  assign bus_io.mul_b     = mul_b_q;

  assign bus_io.done0     = (state_q == S_DONE) & ~gnt_q;
  assign bus_io.done1     = (state_q == S_DONE) &  gnt_q;
  assign bus_io.res0      = res0_q;
  assign bus_io.res1      = res1_q;

`ifdef MUL_ARB_TIMEOUT_EN
  assign bus_io.err0      = (state_q == S_DONE) & ~gnt_q & err_q;
  assign bus_io.err1      = (state_q == S_DONE) &  gnt_q & err_q;
`else
  assign bus_io.err0      = 1'b0;
  assign bus_io.err1      = 1'b0;
`endif

endmodule : mul_share_arbiter
`default_nettype wire
